buffer_pool_pingpong: RTL

- Next-generation buffer pool: X_MESH*X_MAC independent dual-port buffers, each built from two physical banks, set 0 and set 1, used as ping-pong.
- The write side fills one buffer set while the read side drains the other.
- A two-entry set queue with commit/release handshakes hands completed sets from the loader to the MAC array.
- Sits between the DDR loader (write side) and the MAC mesh (read side); adds read-valid tracking the plain pool lacks.

---
 rtl/buffer_pool_pingpong.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/buffer_pool_pingpong.sv
// buffer_pool_pingpong: a pool of BUFFER_NUM dual-port buffers. Each buffer
// is two physical banks (set 0 / set 1) used as ping-pong. The loader fills
// one set while the MAC mesh drains the other. A two-slot full-flag queue with
// commit/release handshakes passes completed sets from the write side to the
// read side.
//
// Optional feature: define BUFFER_POOL_OUT_REG_EN to add a resettable doutb
// output register. Read latency becomes 2 cycles and doutb_valid is delayed to
// match. When it is undefined, latency is 1 and doutb comes straight from the
// bank read port.

// One logical buffer: two banks, one write port and one read port.
module buffer_pool_bank #(
  parameter int ADDR_LEN  = 13,
  parameter int DATA_LEN  = 32,
  parameter int RAM_DEPTH = 2**ADDR_LEN
) (
  input  logic                clk,
  input  logic                we,
  input  logic                wr_set,
  input  logic [ADDR_LEN-1:0] waddr,
  input  logic [DATA_LEN-1:0] din,
  input  logic                re,
  input  logic                rd_set,
  input  logic [ADDR_LEN-1:0] raddr,
  output logic [DATA_LEN-1:0] dout
);

  // Bank contents are never reset. Only the write side can modify them.
  logic [DATA_LEN-1:0] ram0 [RAM_DEPTH];
  logic [DATA_LEN-1:0] ram1 [RAM_DEPTH];
  logic [DATA_LEN-1:0] dout_q;

  // Write port: the set pointer selects which physical bank is filled.
  always_ff @(posedge clk) begin
    if (we && !wr_set) ram0[waddr] <= din;
    if (we &&  wr_set) ram1[waddr] <= din;
  end

  // Registered read port. It holds its last value when not read, which lets
  // it map onto block RAM.
  always_ff @(posedge clk) begin
    if (re) dout_q <= rd_set ? ram1[raddr] : ram0[raddr];
  end

  assign dout = dout_q;

endmodule

// Pool top: ping-pong set control plus an array of per-buffer banks.
module buffer_pool_pingpong #(
  parameter  int X_MAC      = 4,
  parameter  int X_MESH     = 16,
  parameter  int ADDR_LEN   = 13,
  parameter  int DATA_LEN   = 32,
  localparam int RAM_DEPTH  = 2**ADDR_LEN,
  localparam int BUFFER_NUM = X_MAC*X_MESH,
  localparam int DATAWIDTH  = BUFFER_NUM*DATA_LEN,
  localparam int ADDRWIDTH  = BUFFER_NUM*ADDR_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATAWIDTH-1:0]  dina,
  input  logic [ADDRWIDTH-1:0]  addra,
  input  logic [BUFFER_NUM-1:0] wea,
  input  logic                  wr_commit,
  output logic                  wr_ready,
  output logic                  wr_set,
  input  logic [ADDRWIDTH-1:0]  addrb,
  input  logic                  rd_en,
  input  logic                  rd_release,
  output logic                  rd_ready,
  output logic                  rd_set,
  output logic [DATAWIDTH-1:0]  doutb,
  output logic                  doutb_valid
);

`ifdef BUFFER_POOL_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  logic [1:0]          full_q, full_d;
  logic                wr_set_q, wr_set_d;
  logic                rd_set_q, rd_set_d;
  logic [STAGES:1]     vld_pipe_q, vld_pipe_d;
  logic [STAGES:0]     vld_pipe;
  logic                commit_ok, release_ok, rd_acc;
  logic [DATAWIDTH-1:0] bank_dout;

  // Handshake qualification. Both ready signals come straight from registers.
  always_comb begin
    wr_ready   = ~full_q[wr_set_q];
    rd_ready   = full_q[rd_set_q];
    commit_ok  = wr_commit & wr_ready;
    release_ok = rd_release & rd_ready;
    rd_acc     = rd_en & rd_ready;
  end

  // Next-state set control. A valid commit needs an empty slot and a valid
  // release needs a full one, so when both fire together they always address
  // different slots and can be applied independently.
  always_comb begin
    full_d   = full_q;
    wr_set_d = wr_set_q;
    rd_set_d = rd_set_q;
    if (commit_ok) begin
      full_d[wr_set_q] = 1'b1;
      wr_set_d         = ~wr_set_q;
    end
    if (release_ok) begin
      full_d[rd_set_q] = 1'b0;
      rd_set_d         = ~rd_set_q;
    end
  end

  // Read-valid shift register. Stage 0 is this cycle's accepted read.
  assign vld_pipe = {vld_pipe_q, rd_acc};
  always_comb begin
    vld_pipe_d = vld_pipe[STAGES-1:0];
  end

  // State registers. Reset drops any read that is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q     <= '0;
      wr_set_q   <= 1'b0;
      rd_set_q   <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_set_q   <= wr_set_d;
      rd_set_q   <= rd_set_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign wr_set      = wr_set_q;
  assign rd_set      = rd_set_q;
  assign doutb_valid = vld_pipe_q[STAGES];

  // Per-buffer banks. Writes are dropped while no free set is available. A
  // bank never reads and writes the same set at once, because the pointers
  // differ whenever both sides are ready.
  for (genvar i = 0; i < BUFFER_NUM; i++) begin : g_buf
    buffer_pool_bank #(
      .ADDR_LEN (ADDR_LEN),
      .DATA_LEN (DATA_LEN),
      .RAM_DEPTH(RAM_DEPTH)
    ) u_bank (
      .clk   (clk),
      .we    (wea[i] & wr_ready),
      .wr_set(wr_set_q),
      .waddr (addra[i*ADDR_LEN +: ADDR_LEN]),
      .din   (dina[i*DATA_LEN +: DATA_LEN]),
      .re    (rd_acc),
      .rd_set(rd_set_q),
      .raddr (addrb[i*ADDR_LEN +: ADDR_LEN]),
      .dout  (bank_dout[i*DATA_LEN +: DATA_LEN])
    );
  end

`ifdef BUFFER_POOL_OUT_REG_EN
  logic [DATAWIDTH-1:0] doutb_q, doutb_d;

  // Output stage input is the raw bank read data.
  always_comb begin
    doutb_d = bank_dout;
  end

  // Output register. It adds one cycle of latency in exchange for timing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) doutb_q <= '0;
    else     doutb_q <= doutb_d;
  end

  assign doutb = doutb_q;
`else
  assign doutb = bank_dout;
`endif

endmodule
